// File: rtl/output_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// output_port_arbiter_if
// Bundles the request/flit/credit inputs and the grant/select/status outputs of
// one router output-port arbiter. The clock and reset are not in the bundle;
// they stay as plain ports on the arbiter.
//
// Modports
//   master : side that drives requests/flit ids/credit returns (input VCs, bench)
//   slave  : the arbiter itself
//
// Signals
//   req_i        [IN_N]              input k's current flit is routed here
//   data_vld_i   [IN_N]              input k's VC holds a valid flit
//   flit_id_i    [IN_N*FLIT_ID_W]    flit type of input k at [k*FLIT_ID_W +: FLIT_ID_W]
//   credit_ret_i                     downstream freed one buffer slot
//   grant_o      [IN_N]              one-hot pop of the granted input VC
//   sel_o        [$clog2(IN_N)]      crossbar select
//   out_vld_o                        a flit moves this cycle
//   credit_cnt_o [$clog2(CREDIT_N+1)] registered credit count
//   busy_o                           a packet currently owns the output
//   err_o                            sticky protocol error flag
// ----------------------------------------------------------------------------
interface output_port_arbiter_if #(
    parameter int IN_N      = 5,
    parameter int FLIT_ID_W = 2,
    parameter int CREDIT_N  = 4
);
    logic [IN_N-1:0]                   req_i;
    logic [IN_N-1:0]                   data_vld_i;
    logic [IN_N*FLIT_ID_W-1:0]         flit_id_i;
    logic                              credit_ret_i;
    logic [IN_N-1:0]                   grant_o;
    logic [$clog2(IN_N)-1:0]           sel_o;
    logic                              out_vld_o;
    logic [$clog2(CREDIT_N+1)-1:0]     credit_cnt_o;
    logic                              busy_o;
    logic                              err_o;

    modport master (
        output req_i, data_vld_i, flit_id_i, credit_ret_i,
        input  grant_o, sel_o, out_vld_o, credit_cnt_o, busy_o, err_o
    );

    modport slave (
        input  req_i, data_vld_i, flit_id_i, credit_ret_i,
        output grant_o, sel_o, out_vld_o, credit_cnt_o, busy_o, err_o
    );
endinterface

// File: rtl/output_port_arbiter.sv
// ----------------------------------------------------------------------------
// output_port_arbiter
// Wormhole output-port arbiter with credit flow control for one router output.
// Round-robin picks among inputs presenting a HEAD/HEAD_TAIL flit, then locks
// the output to the winner until its TAIL transfers. A downstream credit
// counter gates every transfer. The grant is combinational (0-cycle) so a new
// packet may win in the cycle right after a tail.
//
// Ports
//   clk_i  : clock, all state on the rising edge
//   rst_i  : synchronous active-high reset
//   bus    : output_port_arbiter_if.slave (requests, flit ids, credit returns
//            in; grant, select, valid, credit count, busy, error out)
//
// Build option
//   OUTARB_ERR_CHK_EN : when defined, err_o is a sticky flag raised by a
//   BODY/TAIL presented in IDLE, a HEAD transferred by the owner while locked,
//   or a credit return with the counter already full. When undefined the
//   checker is absent and err_o is tied low; the datapath is unaffected.
// ----------------------------------------------------------------------------
module output_port_arbiter #(
    parameter int IN_N        = 5,
    parameter int FLIT_ID_W   = 2,
    parameter int CREDIT_N    = 4,
    parameter int OUT_CHAN_ID = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output_port_arbiter_if.slave  bus
);
    localparam int SEL_W = $clog2(IN_N);
    localparam int CNT_W = $clog2(CREDIT_N + 1);

    localparam logic [1:0] FID_HEAD = 2'b01;

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  owner_reg, owner_next;
    logic [SEL_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic [CNT_W-1:0]  credit_cnt_reg, credit_cnt_next;
    logic              err_reg;

    logic [IN_N-1:0]   cand;
    logic [IN_N-1:0]   eligible;
    logic [1:0]        fid [IN_N];
    logic [SEL_W-1:0]  winner;
    logic              any_elig;
    logic              can_send;
    logic [IN_N-1:0]   grant;
    logic              xfer;

    // The channel index only labels this instance; no logic depends on it.
    if (OUT_CHAN_ID < 0) begin : g_chan_id_label
    end

    // Per-input decode. Bit 0 of the flit id marks a packet start
    // (HEAD or HEAD_TAIL), bit 1 marks a packet end (TAIL or HEAD_TAIL).
    for (genvar gi = 0; gi < IN_N; gi++) begin : g_in
        assign fid[gi]      = bus.flit_id_i[gi*FLIT_ID_W +: 2];
        assign cand[gi]     = bus.req_i[gi] & bus.data_vld_i[gi];
        assign eligible[gi] = cand[gi] & fid[gi][0];
    end

    assign can_send = (credit_cnt_reg != '0);

    // Round-robin search. Offsets are scanned from the farthest back to the
    // nearest so the last hit (closest to rr_ptr+1) is the one that sticks.
    always_comb begin
        int sum;
        logic [SEL_W-1:0] idx;
        sum      = 0;
        idx      = '0;
        winner   = '0;
        any_elig = 1'b0;
        for (int off = IN_N; off >= 1; off--) begin
            sum = int'(rr_ptr_reg) + off;
            if (sum >= IN_N) sum = sum - IN_N;
            idx = SEL_W'(sum);
            if (eligible[idx]) begin
                winner   = idx;
                any_elig = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= '0;
            rr_ptr_reg     <= SEL_W'(IN_N - 1);
            sel_reg        <= '0;
            credit_cnt_reg <= CNT_W'(CREDIT_N);
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            rr_ptr_reg     <= rr_ptr_next;
            sel_reg        <= sel_next;
            credit_cnt_reg <= credit_cnt_next;
        end
    end

    // Output logic: grant and crossbar select. Everything is gated during
    // reset so no VC is popped while the state is being cleared.
    always_comb begin
        grant    = '0;
        sel_next = sel_reg;
        if (rst_i) begin
            sel_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_elig && can_send) begin
                        grant[winner] = 1'b1;
                        sel_next      = winner;
                    end
                end
                ST_LOCKED: begin
                    sel_next = owner_reg;
                    if (cand[owner_reg] && can_send) grant[owner_reg] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign xfer = |grant;

    // Next-state logic: packet locking, round-robin pointer and credits.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        rr_ptr_next     = rr_ptr_reg;
        credit_cnt_next = credit_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (xfer) begin
                    rr_ptr_next = winner;
                    if (fid[winner] == FID_HEAD) begin
                        state_next = ST_LOCKED;
                        owner_next = winner;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer && fid[owner_reg][1]) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // A transfer never happens at zero credits, so the decrement cannot
        // wrap; an increment at full is dropped (saturation).
        if (xfer && !bus.credit_ret_i) begin
            credit_cnt_next = credit_cnt_reg - CNT_W'(1);
        end else if (!xfer && bus.credit_ret_i &&
                     credit_cnt_reg != CNT_W'(CREDIT_N)) begin
            credit_cnt_next = credit_cnt_reg + CNT_W'(1);
        end
    end

`ifdef OUTARB_ERR_CHK_EN
    logic [IN_N-1:0] bad_idle;
    logic            err_set;

    for (genvar gi = 0; gi < IN_N; gi++) begin : g_chk
        assign bad_idle[gi] = cand[gi] & ~fid[gi][0];
    end

    assign err_set = ((state_reg == ST_IDLE) && (|bad_idle)) ||
                     ((state_reg == ST_LOCKED) && xfer && (fid[owner_reg] == FID_HEAD)) ||
                     (!xfer && bus.credit_ret_i && credit_cnt_reg == CNT_W'(CREDIT_N));

    always_ff @(posedge clk_i) begin
        if (rst_i)        err_reg <= 1'b0;
        else if (err_set) err_reg <= 1'b1;
    end
`else
    assign err_reg = 1'b0;
`endif

    assign bus.grant_o      = grant;
    assign bus.sel_o        = sel_next;
    assign bus.out_vld_o    = xfer;
    assign bus.credit_cnt_o = credit_cnt_reg;
    assign bus.busy_o       = (state_reg == ST_LOCKED);
    assign bus.err_o        = err_reg;
endmodule

// File: tb/tb_output_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_output_port_arbiter
// Directed stimulus for the output-port arbiter. Each expected transfer is
// queued with the cycle it must occur in; a negedge monitor pops and compares
// every transfer the arbiter presents and flags missing or unexpected ones.
// Registered status (credit count, busy, error, select) is compared directly
// from the stimulus process one time unit after the clock edge.
// ----------------------------------------------------------------------------
module tb_output_port_arbiter;
    localparam int IN_N      = 5;
    localparam int FLIT_ID_W = 2;
    localparam int CREDIT_N  = 4;

    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] HT   = 2'b11;

`ifdef OUTARB_ERR_CHK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    output_port_arbiter_if #(.IN_N(IN_N), .FLIT_ID_W(FLIT_ID_W), .CREDIT_N(CREDIT_N)) bus ();

    output_port_arbiter #(
        .IN_N(IN_N), .FLIT_ID_W(FLIT_ID_W), .CREDIT_N(CREDIT_N), .OUT_CHAN_ID(0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [IN_N-1:0] grant;
        logic [2:0]      sel;
        int              at_cyc;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_vld_o !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_xfer cyc=%0d grant=%b sel=%0d required=no transfer",
                         cyc, bus.grant_o, bus.sel_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.grant_o !== e.grant || bus.sel_o !== e.sel || e.at_cyc != cyc) begin
                    errors++;
                    $display("FAIL xfer cyc=%0d grant=%b sel=%0d required grant=%b sel=%0d at cyc=%0d",
                             cyc, bus.grant_o, bus.sel_o, e.grant, e.sel, e.at_cyc);
                end else begin
                    $display("xfer cyc=%0d grant=%b sel=%0d cnt=%0d",
                             cyc, bus.grant_o, bus.sel_o, bus.credit_cnt_o);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].at_cyc == cyc) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL missing_xfer cyc=%0d grant=%b required grant=%b sel=%0d",
                     cyc, bus.grant_o, e.grant, e.sel);
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.req_i      = '0;
        bus.data_vld_i = '0;
        bus.flit_id_i  = '0;
    endtask

    task automatic drive(input int k, input logic [1:0] id);
        bus.req_i[k]                      = 1'b1;
        bus.data_vld_i[k]                 = 1'b1;
        bus.flit_id_i[k*FLIT_ID_W +: 2]   = id;
    endtask

    task automatic expect_xfer(input int k);
        exp_t e;
        e.grant    = '0;
        e.grant[k] = 1'b1;
        e.sel      = 3'(k);
        e.at_cyc   = cyc;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        clr_in();
        bus.credit_ret_i = 1'b0;
        step();
        step();
        chk("rst_cnt",   32'(bus.credit_cnt_o), 4);
        chk("rst_busy",  32'(bus.busy_o), 0);
        chk("rst_err",   32'(bus.err_o), 0);
        chk("rst_sel",   32'(bus.sel_o), 0);
        chk("rst_vld",   32'(bus.out_vld_o), 0);
        rst = 1'b0;

        // 1: single HEAD_TAIL from input 2
        drive(2, HT); expect_xfer(2); step(); clr_in();
        chk("t1_cnt",  32'(bus.credit_cnt_o), 3);
        chk("t1_busy", 32'(bus.busy_o), 0);
        chk("t1_sel_hold", 32'(bus.sel_o), 2);
        bus.credit_ret_i = 1'b1; step(); bus.credit_ret_i = 1'b0;
        chk("t1_ret_cnt", 32'(bus.credit_cnt_o), 4);

        // 2: move rr_ptr to 4 (transfer + return at full: no change)
        drive(4, HT); bus.credit_ret_i = 1'b1; expect_xfer(4); step();
        clr_in(); bus.credit_ret_i = 1'b0;
        chk("t2_xfer_ret_full", 32'(bus.credit_cnt_o), 4);
        drive(1, HEAD); drive(3, HEAD); expect_xfer(1); step();
        chk("t2_busy_lock", 32'(bus.busy_o), 1);
        chk("t2_cnt", 32'(bus.credit_cnt_o), 3);
        bus.credit_ret_i = 1'b1;
        drive(1, BODY); expect_xfer(1); step();
        chk("t2_still_locked", 32'(bus.busy_o), 1);
        drive(1, TAIL); expect_xfer(1); step();
        chk("t2_tail_idle", 32'(bus.busy_o), 0);
        bus.req_i[1] = 1'b0; bus.data_vld_i[1] = 1'b0;
        expect_xfer(3); step();
        chk("t2_lock3", 32'(bus.busy_o), 1);
        chk("t2_cnt_hold", 32'(bus.credit_cnt_o), 3);
        bus.credit_ret_i = 1'b0;
        drive(3, TAIL); expect_xfer(3); step(); clr_in();
        chk("t2_idle3", 32'(bus.busy_o), 0);
        chk("t2_cnt2", 32'(bus.credit_cnt_o), 2);
        bus.credit_ret_i = 1'b1; step(); step(); bus.credit_ret_i = 1'b0;
        chk("t2_refill", 32'(bus.credit_cnt_o), 4);

        // 3: 6-flit packet with only 4 credits
        drive(0, HEAD); expect_xfer(0); step();
        drive(0, BODY);
        expect_xfer(0); step();
        expect_xfer(0); step();
        expect_xfer(0); step();
        chk("t3_cnt0", 32'(bus.credit_cnt_o), 0);
        chk("t3_busy", 32'(bus.busy_o), 1);
        step(); step();
        chk("t3_stall_cnt", 32'(bus.credit_cnt_o), 0);
        bus.credit_ret_i = 1'b1; step(); bus.credit_ret_i = 1'b0;
        chk("t3_ret_cnt", 32'(bus.credit_cnt_o), 1);
        expect_xfer(0); step();
        chk("t3_5th_cnt", 32'(bus.credit_cnt_o), 0);
        bus.credit_ret_i = 1'b1; step(); bus.credit_ret_i = 1'b0;
        drive(0, TAIL); expect_xfer(0); step(); clr_in();
        chk("t3_end_cnt", 32'(bus.credit_cnt_o), 0);
        chk("t3_end_busy", 32'(bus.busy_o), 0);

        // 4: transfer+return at cnt=1, then overflow at full
        bus.credit_ret_i = 1'b1; step();
        drive(2, HT); expect_xfer(2); step(); clr_in();
        chk("t4_cnt_hold1", 32'(bus.credit_cnt_o), 1);
        step(); step(); step();
        chk("t4_cnt_full", 32'(bus.credit_cnt_o), 4);
        chk("t4_err_pre", 32'(bus.err_o), 0);
        step(); bus.credit_ret_i = 1'b0;
        chk("t4_cnt_sat", 32'(bus.credit_cnt_o), 4);
        chk("t4_err_ovf", 32'(bus.err_o), 32'(EXP_ERR));

        // 5: reset in the middle of a packet
        drive(1, HEAD); expect_xfer(1); step();
        drive(1, BODY); expect_xfer(1); step();
        chk("t5_busy", 32'(bus.busy_o), 1);
        chk("t5_cnt2", 32'(bus.credit_cnt_o), 2);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_rst_busy", 32'(bus.busy_o), 0);
        chk("t5_rst_cnt", 32'(bus.credit_cnt_o), 4);
        chk("t5_rst_err", 32'(bus.err_o), 0);
        chk("t5_rst_sel", 32'(bus.sel_o), 0);
        step();
        chk("t5_body_idle_err", 32'(bus.err_o), 32'(EXP_ERR));
        chk("t5_body_idle_cnt", 32'(bus.credit_cnt_o), 4);
        clr_in();

        // 6: all inputs stream HEAD_TAIL, credits returned every cycle
        for (int k = 0; k < IN_N; k++) drive(k, HT);
        bus.credit_ret_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_xfer(i % IN_N);
            step();
        end
        clr_in(); bus.credit_ret_i = 1'b0;
        chk("t6_cnt", 32'(bus.credit_cnt_o), 4);
        chk("t6_busy", 32'(bus.busy_o), 0);

        step(); step();
        chk("queue_drain", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
